pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the MIPS core.
- Holds the PC and fetches each instruction from instruction memory over a request/acknowledge handshake.
- Presents the fetched instruction downstream to the decoder and sign extender.
- Computes the next PC from PC+4, the sign-extended immediate returned by the sign extender (branch), or the 26-bit jump field.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word.
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles IMEM_REQ may stay unacknowledged before FETCH_ERR is raised.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset; asynchronous, active-high.
- IMEM_REQ  output  1  fetch request to instruction memory.
- IMEM_ADDR  output  DATA_WIDTH  fetch address; always equals PC.
- IMEM_ACK  input  1  memory acknowledges; IMEM_RDATA is valid this cycle.
- IMEM_RDATA  input  DATA_WIDTH  fetched instruction word.
- INSTR  output  DATA_WIDTH  registered instruction presented to decode.
- INSTR_VALID  output  1  INSTR holds a valid, not-yet-retired instruction.
- STALL  input  1  downstream cannot retire INSTR this cycle.
- BRANCH  input  1  retiring instruction is a taken branch.
- JUMP  input  1  retiring instruction is a jump; takes priority over BRANCH.
- SignImm  input  DATA_WIDTH  sign-extended immediate of INSTR.
- PC  output  DATA_WIDTH  address of the current instruction.
- PCPlus4  output  DATA_WIDTH  PC+4, combinational, modulo 2^DATA_WIDTH.
- FETCH_ERR  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (RST=1, asynchronous, immediate): PC=RESET_ADDR, INSTR=0, INSTR_VALID=0, IMEM_REQ=0, FETCH_ERR=0, wait counter=0, state=BOOT. Reset in any state, including mid-handshake, discards everything; an IMEM_ACK during reset is ignored.
- BOOT: IMEM_REQ=0. On the first clock after RST deasserts, go to FETCH.
- FETCH:
  - IMEM_REQ=1 and IMEM_ADDR=PC; both stay stable until ACK.
  - On IMEM_ACK: INSTR<=IMEM_RDATA, INSTR_VALID<=1, counter<=0, go to ISSUED.
  - No ACK: counter increments. When counter reaches MAX_WAIT without ACK: FETCH_ERR<=1, go to ERROR.
  - An ACK in the same cycle the counter reaches MAX_WAIT is accepted and no error is raised.
- ISSUED:
  - IMEM_REQ=0. IMEM_ACK is ignored.
  - STALL=1: INSTR, PC and INSTR_VALID hold; BRANCH, JUMP and SignImm are not sampled.
  - STALL=0: the instruction retires. PC is loaded with:
    - JUMP=1: {PCPlus4[31:28], INSTR[25:0], 2'b00}.
    - else BRANCH=1: PCPlus4 + {SignImm[29:0], 2'b00}, truncated to 32 bits (wraps, no overflow flag).
    - else: PCPlus4.
  - On retire, INSTR_VALID<=0 and state goes to FETCH. INSTR keeps its old value while invalid.
- ERROR: IMEM_REQ=0, INSTR_VALID=0, PC frozen. Left only by reset. FETCH_ERR is sticky until reset.
- Throughput: at minimum 2 cycles per instruction (FETCH with same-cycle ACK, then ISSUED with STALL=0). Each extra memory wait cycle or STALL cycle adds 1.
- PC is always word-aligned: RESET_ADDR[1:0] must be 0; all computed targets have [1:0]=0.
- PCPlus4 of 32'hFFFF_FFFC wraps to 0.

Test Plan:
- Reset then ACK every FETCH cycle with STALL=0 and no branch or jump -> IMEM_ADDR sequence 0x0, 0x4, 0x8; INSTR_VALID high every other cycle.
- At PC=0x100, SignImm=32'hFFFF_FFFE, BRANCH=1, STALL=0 -> next IMEM_ADDR=0xFC. With SignImm=0x10 -> 0x144.
- At PC=0x1000_0000, INSTR[25:0]=26'h000_0040, JUMP=1 and BRANCH=1 -> next PC=0x1000_0100 (jump wins).
- Hold STALL=1 for 3 cycles while toggling BRANCH -> PC and INSTR unchanged, INSTR_VALID stays 1; drop STALL with BRANCH=0 -> PC advances by 4 only.
- No IMEM_ACK for MAX_WAIT=15 cycles -> FETCH_ERR=1 on the next cycle, IMEM_REQ=0, later ACKs ignored. Pulse RST -> FETCH_ERR=0, PC=RESET_ADDR. An ACK arriving exactly at the limit is accepted with no error.
- Assert RST asynchronously mid-FETCH with IMEM_ACK=1 -> outputs reset immediately, INSTR stays 0, fetch restarts at RESET_ADDR after BOOT.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage with a request/acknowledge
// memory handshake, a fetch-timeout guard and branch/jump next-PC selection.
module pc_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    MAX_WAIT   = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  IMEM_REQ,
    output logic [DATA_WIDTH-1:0] IMEM_ADDR,
    input  logic                  IMEM_ACK,
    input  logic [DATA_WIDTH-1:0] IMEM_RDATA,
    output logic [DATA_WIDTH-1:0] INSTR,
    output logic                  INSTR_VALID,
    input  logic                  STALL,
    input  logic                  BRANCH,
    input  logic                  JUMP,
    input  logic [DATA_WIDTH-1:0] SignImm,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  FETCH_ERR
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {BOOT, FETCH, ISSUED, ERROR} state_t;

    state_t                state;
    logic [CW-1:0]         wait_cnt;
    logic [DATA_WIDTH-1:0] target;

    assign PCPlus4   = PC + DATA_WIDTH'(4);
    assign IMEM_ADDR = PC;

    // Jump beats branch; the shift drops the immediate's top two bits, giving wrap-around targets.
    always_comb
        target = JUMP   ? {PCPlus4[DATA_WIDTH-1:28], INSTR[25:0], 2'b00} :
                 BRANCH ? PCPlus4 + (SignImm << 2) : PCPlus4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= BOOT;
            PC          <= RESET_ADDR;
            INSTR       <= '0;
            INSTR_VALID <= 1'b0;
            IMEM_REQ    <= 1'b0;
            FETCH_ERR   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    IMEM_REQ <= 1'b1;
                end
                FETCH: begin
                    if (IMEM_ACK) begin
                        INSTR       <= IMEM_RDATA;
                        INSTR_VALID <= 1'b1;
                        IMEM_REQ    <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= ISSUED;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                        // This unacknowledged cycle is the last one allowed.
                        if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                            FETCH_ERR <= 1'b1;
                            IMEM_REQ  <= 1'b0;
                            state     <= ERROR;
                        end
                    end
                end
                ISSUED: begin
                    if (!STALL) begin
                        PC          <= target;
                        INSTR_VALID <= 1'b0;
                        IMEM_REQ    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                ERROR: begin
                    IMEM_REQ    <= 1'b0;
                    INSTR_VALID <= 1'b0;
                end
            endcase
        end
    end
endmodule
